// File: rtl/dcache_victim_ctrl.sv
// Dcache miss controller: probes the victim cache, falls back to memory, refills the dcache
// and parks the displaced line. Optional hit/miss counters are enabled by VICTIM_STATS_EN.
module dcache_victim_ctrl #(
  parameter int DCACHE_LINE_WIDTH = 128,
  parameter int DCACHE_TAG_BITS   = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req_i,
  input  logic [DCACHE_TAG_BITS-1:0]   miss_tag_i,
  input  logic                         evict_valid_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
  input  logic [DCACHE_TAG_BITS-1:0]   evict_tag_i,
  output logic [DCACHE_TAG_BITS-1:0]   victim_lookup_tag_o,
  input  logic                         victim_hit_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] victim_data_i,
  output logic                         write_to_victim_o,
  output logic [DCACHE_LINE_WIDTH-1:0] victim_wdata_o,
  output logic [DCACHE_TAG_BITS-1:0]   victim_wtag_o,
  output logic                         mem_req_o,
  output logic [DCACHE_TAG_BITS-1:0]   mem_tag_o,
  input  logic                         mem_ack_i,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
  output logic                         fill_valid_o,
  output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
  output logic [DCACHE_TAG_BITS-1:0]   fill_tag_o,
  output logic                         fill_from_victim_o,
  output logic                         ready_o
`ifdef VICTIM_STATS_EN
  ,
  output logic [15:0]                  victim_hits_o,
  output logic [15:0]                  victim_misses_o
`endif
);

  typedef enum logic [1:0] {IDLE, PROBE, MEM_REQ, FILL} state_e;

  state_e                         state_q;
  logic [DCACHE_TAG_BITS-1:0]     tag_q;
  logic [DCACHE_TAG_BITS-1:0]     lookup_tag_q;
  logic                           evict_valid_q;
  logic [DCACHE_LINE_WIDTH-1:0]   evict_data_q;
  logic [DCACHE_TAG_BITS-1:0]     evict_tag_q;
  logic [DCACHE_LINE_WIDTH-1:0]   line_q;
  logic                           src_victim_q;
  logic                           ready_q;
  logic                           mem_req_q;
  logic                           fill_valid_q;
  logic                           wr_victim_q;
  logic                           probe_hit;

  // Tag 0 is what reset-state victim entries hold, so it can never be a genuine hit.
  assign probe_hit = (state_q == PROBE) && victim_hit_i && (tag_q != '0);

  // NOTE: state uses non-blocking assignments and an async reset so every register
  // updates together on the edge and clears the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      lookup_tag_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      evict_tag_q   <= '0;
      line_q        <= '0;
      src_victim_q  <= 1'b0;
      ready_q       <= 1'b1;
      mem_req_q     <= 1'b0;
      fill_valid_q  <= 1'b0;
      wr_victim_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_req_i) begin
            tag_q         <= miss_tag_i;
            lookup_tag_q  <= miss_tag_i;
            evict_valid_q <= evict_valid_i;
            evict_data_q  <= evict_data_i;
            evict_tag_q   <= evict_tag_i;
            ready_q       <= 1'b0;
            state_q       <= PROBE;
          end
        end
        PROBE: begin
          lookup_tag_q <= '0;
          if (probe_hit) begin
            line_q       <= victim_data_i;
            src_victim_q <= 1'b1;
            fill_valid_q <= 1'b1;
            wr_victim_q  <= evict_valid_q;
            state_q      <= FILL;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ack_i) begin
            line_q       <= mem_data_i;
            src_victim_q <= 1'b0;
            mem_req_q    <= 1'b0;
            fill_valid_q <= 1'b1;
            wr_victim_q  <= evict_valid_q;
            state_q      <= FILL;
          end
        end
        FILL: begin
          fill_valid_q <= 1'b0;
          wr_victim_q  <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          lookup_tag_q <= '0;
          mem_req_q    <= 1'b0;
          fill_valid_q <= 1'b0;
          wr_victim_q  <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign ready_o             = ready_q;
  assign victim_lookup_tag_o = lookup_tag_q;
  assign mem_req_o           = mem_req_q;
  assign mem_tag_o           = tag_q;
  assign fill_valid_o        = fill_valid_q;
  assign fill_data_o         = line_q;
  assign fill_tag_o          = tag_q;
  assign fill_from_victim_o  = src_victim_q;
  assign write_to_victim_o   = wr_victim_q;
  assign victim_wdata_o      = evict_data_q;
  assign victim_wtag_o       = evict_tag_q;

`ifdef VICTIM_STATS_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;
  logic        probe_miss;

  assign probe_miss = (state_q == PROBE) && !probe_hit;

  // NOTE: next-state values get a default first so no path through the block infers a latch.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (probe_hit && (hits_q != 16'hFFFF))
      hits_d = hits_q + 16'd1;
    if (probe_miss && (misses_q != 16'hFFFF))
      misses_d = misses_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign victim_hits_o   = hits_q;
  assign victim_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// Directed bench for dcache_victim_ctrl: expected refills are queued when a request is
// issued and compared by a monitor when fill_valid_o rises. Stats checks need VICTIM_STATS_EN.
module tb_dcache_victim_ctrl;

  localparam int LW = 128;
  localparam int TW = 23;

  typedef struct {
    logic [LW-1:0] data;
    logic [TW-1:0] tag;
    logic          src;
    logic          wr;
    logic [LW-1:0] wdata;
    logic [TW-1:0] wtag;
  } fill_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_req_i = 1'b0;
  logic [TW-1:0] miss_tag_i = '0;
  logic          evict_valid_i = 1'b0;
  logic [LW-1:0] evict_data_i = '0;
  logic [TW-1:0] evict_tag_i = '0;
  logic [TW-1:0] victim_lookup_tag_o;
  logic          victim_hit_i = 1'b0;
  logic [LW-1:0] victim_data_i = '0;
  logic          write_to_victim_o;
  logic [LW-1:0] victim_wdata_o;
  logic [TW-1:0] victim_wtag_o;
  logic          mem_req_o;
  logic [TW-1:0] mem_tag_o;
  logic          mem_ack_i = 1'b0;
  logic [LW-1:0] mem_data_i = '0;
  logic          fill_valid_o;
  logic [LW-1:0] fill_data_o;
  logic [TW-1:0] fill_tag_o;
  logic          fill_from_victim_o;
  logic          ready_o;
`ifdef VICTIM_STATS_EN
  logic [15:0]   victim_hits_o;
  logic [15:0]   victim_misses_o;
`endif

  int    total = 0;
  int    passed = 0;
  int    fill_count = 0;
  int    fc0;
  fill_t sb_q[$];

  dcache_victim_ctrl #(.DCACHE_LINE_WIDTH(LW), .DCACHE_TAG_BITS(TW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_req_i          (miss_req_i),
    .miss_tag_i          (miss_tag_i),
    .evict_valid_i       (evict_valid_i),
    .evict_data_i        (evict_data_i),
    .evict_tag_i         (evict_tag_i),
    .victim_lookup_tag_o (victim_lookup_tag_o),
    .victim_hit_i        (victim_hit_i),
    .victim_data_i       (victim_data_i),
    .write_to_victim_o   (write_to_victim_o),
    .victim_wdata_o      (victim_wdata_o),
    .victim_wtag_o       (victim_wtag_o),
    .mem_req_o           (mem_req_o),
    .mem_tag_o           (mem_tag_o),
    .mem_ack_i           (mem_ack_i),
    .mem_data_i          (mem_data_i),
    .fill_valid_o        (fill_valid_o),
    .fill_data_o         (fill_data_o),
    .fill_tag_o          (fill_tag_o),
    .fill_from_victim_o  (fill_from_victim_o),
    .ready_o             (ready_o)
`ifdef VICTIM_STATS_EN
    ,
    .victim_hits_o       (victim_hits_o),
    .victim_misses_o     (victim_misses_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one miss for a single cycle; returns with the DUT in PROBE.
  task automatic issue(input logic [TW-1:0] tag, input logic ev, input logic [LW-1:0] ed,
                       input logic [TW-1:0] et);
    miss_req_i    = 1'b1;
    miss_tag_i    = tag;
    evict_valid_i = ev;
    evict_data_i  = ed;
    evict_tag_i   = et;
    step();
    miss_req_i    = 1'b0;
    evict_valid_i = 1'b0;
  endtask

  task automatic push(input logic [LW-1:0] d, input logic [TW-1:0] t, input logic s,
                      input logic w, input logic [LW-1:0] wd, input logic [TW-1:0] wt);
    fill_t e;
    e.data = d; e.tag = t; e.src = s; e.wr = w; e.wdata = wd; e.wtag = wt;
    sb_q.push_back(e);
  endtask

  // Refill monitor, sampling mid-cycle.
  always @(negedge clk) begin
    fill_t e;
    check("stray_victim_write", LW'(write_to_victim_o & ~fill_valid_o), '0);
    if (fill_valid_o) begin
      fill_count++;
      check("fill_expected", LW'(sb_q.size() != 0), LW'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("fill_data", fill_data_o, e.data);
        check("fill_tag", LW'(fill_tag_o), LW'(e.tag));
        check("fill_from_victim", LW'(fill_from_victim_o), LW'(e.src));
        check("victim_write", LW'(write_to_victim_o), LW'(e.wr));
        if (e.wr) begin
          check("victim_wdata", victim_wdata_o, e.wdata);
          check("victim_wtag", LW'(victim_wtag_o), LW'(e.wtag));
        end
      end
    end
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_ready", LW'(ready_o), LW'(1));
    check("rst_fill_valid", LW'(fill_valid_o), '0);
    check("rst_mem_req", LW'(mem_req_o), '0);
    check("rst_lookup", LW'(victim_lookup_tag_o), '0);
    check("rst_fill_data", fill_data_o, '0);
    check("rst_mem_tag", LW'(mem_tag_o), '0);
    check("rst_wdata", victim_wdata_o, '0);
    rst = 1'b1;
    step();

    // Victim hit with eviction
    issue(23'h1A5, 1'b1, 128'hE1E1_0000_1111_2222_3333_4444_5555_6666, 23'h0777);
    check("hit_lookup_tag", LW'(victim_lookup_tag_o), LW'(23'h1A5));
    check("hit_probe_not_ready", LW'(ready_o), '0);
    push(128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF, 23'h1A5, 1'b1, 1'b1,
         128'hE1E1_0000_1111_2222_3333_4444_5555_6666, 23'h0777);
    victim_hit_i  = 1'b1;
    victim_data_i = 128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF;
    step();
    victim_hit_i  = 1'b0;
    check("hit_fill_n2", LW'(fill_valid_o), LW'(1));
    check("hit_write_n2", LW'(write_to_victim_o), LW'(1));
    check("hit_lookup_cleared", LW'(victim_lookup_tag_o), '0);
    check("hit_no_mem_req", LW'(mem_req_o), '0);
    step();
    check("hit_ready_n3", LW'(ready_o), LW'(1));
    check("hit_fill_dropped", LW'(fill_valid_o), '0);

    // Victim miss, memory acks in the third request cycle
    issue(23'h0A0, 1'b1, 128'h5A5A_5A5A, 23'h0123);
    check("miss_lookup_tag", LW'(victim_lookup_tag_o), LW'(23'h0A0));
    push(128'hFEED_FACE_CAFE_BEEF, 23'h0A0, 1'b0, 1'b1, 128'h5A5A_5A5A, 23'h0123);
    step();
    for (int i = 0; i < 3; i++) begin
      check("miss_mem_req_held", LW'(mem_req_o), LW'(1));
      check("miss_mem_tag", LW'(mem_tag_o), LW'(23'h0A0));
      check("miss_no_early_fill", LW'(fill_valid_o), '0);
      if (i == 2) begin
        mem_ack_i  = 1'b1;
        mem_data_i = 128'hFEED_FACE_CAFE_BEEF;
      end
      step();
    end
    mem_ack_i = 1'b0;
    check("miss_mem_req_dropped", LW'(mem_req_o), '0);
    check("miss_fill", LW'(fill_valid_o), LW'(1));
    step();
    check("miss_ready", LW'(ready_o), LW'(1));
    check("miss_fill_data_held", fill_data_o, 128'hFEED_FACE_CAFE_BEEF);

    // Zero tag is never a victim hit
    issue(23'h0, 1'b0, '0, '0);
    push(128'h0BAD_F00D, 23'h0, 1'b0, 1'b0, '0, '0);
    victim_hit_i  = 1'b1;
    victim_data_i = 128'hDEAD_DEAD;
    step();
    victim_hit_i  = 1'b0;
    check("zero_tag_mem_req", LW'(mem_req_o), LW'(1));
    check("zero_tag_no_fill", LW'(fill_valid_o), '0);
    mem_ack_i  = 1'b1;
    mem_data_i = 128'h0BAD_F00D;
    step();
    mem_ack_i = 1'b0;
    check("zero_tag_fill", LW'(fill_valid_o), LW'(1));
    step();

    // Second request during MEM_REQ and stray ack in IDLE are ignored
    fc0 = fill_count;
    issue(23'h3C3, 1'b0, '0, '0);
    push(128'h1234_5678, 23'h3C3, 1'b0, 1'b0, '0, '0);
    step();
    miss_req_i = 1'b1;
    miss_tag_i = 23'h7FF;
    step();
    check("busy_not_ready", LW'(ready_o), '0);
    check("busy_tag_kept", LW'(mem_tag_o), LW'(23'h3C3));
    miss_req_i = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = 128'h1234_5678;
    step();
    mem_ack_i = 1'b0;
    step();
    mem_ack_i  = 1'b1;
    mem_data_i = 128'h9999_9999;
    step();
    mem_ack_i = 1'b0;
    check("stray_ack_no_mem_req", LW'(mem_req_o), '0);
    check("stray_ack_ready", LW'(ready_o), LW'(1));
    check("stray_ack_no_fill", LW'(fill_valid_o), '0);
    check("stray_ack_data_kept", fill_data_o, 128'h1234_5678);
    repeat (3) step();
    check("single_fill", LW'(fill_count - fc0), LW'(1));

    // Reset during MEM_REQ aborts the transaction
    fc0 = fill_count;
    issue(23'h155, 1'b1, 128'h7777, 23'h0042);
    step();
    check("abort_mem_req_before", LW'(mem_req_o), LW'(1));
    #2 rst = 1'b0;
    #1;
    check("abort_mem_req_async", LW'(mem_req_o), '0);
    check("abort_ready", LW'(ready_o), LW'(1));
    check("abort_fill_data", fill_data_o, '0);
    check("abort_wdata", victim_wdata_o, '0);
    check("abort_fill_tag", LW'(fill_tag_o), '0);
    step();
    rst        = 1'b1;
    mem_ack_i  = 1'b1;
    mem_data_i = 128'h4444;
    step();
    mem_ack_i = 1'b0;
    repeat (4) step();
    check("abort_no_fill", LW'(fill_count - fc0), '0);
    check("abort_ready_after", LW'(ready_o), LW'(1));

`ifdef VICTIM_STATS_EN
    for (int i = 0; i < 2; i++) begin
      issue(23'h011 + 23'(i), 1'b0, '0, '0);
      push(128'h6060 + LW'(i), 23'h011 + 23'(i), 1'b1, 1'b0, '0, '0);
      victim_hit_i  = 1'b1;
      victim_data_i = 128'h6060 + LW'(i);
      step();
      victim_hit_i  = 1'b0;
      step();
    end
    issue(23'h022, 1'b0, '0, '0);
    push(128'h7070, 23'h022, 1'b0, 1'b0, '0, '0);
    step();
    mem_ack_i  = 1'b1;
    mem_data_i = 128'h7070;
    step();
    mem_ack_i = 1'b0;
    step();
    check("stats_hits", LW'(victim_hits_o), LW'(2));
    check("stats_misses", LW'(victim_misses_o), LW'(1));
    force dut.hits_q = 16'hFFFF;
    #1;
    release dut.hits_q;
    issue(23'h033, 1'b0, '0, '0);
    push(128'h8080, 23'h033, 1'b1, 1'b0, '0, '0);
    victim_hit_i  = 1'b1;
    victim_data_i = 128'h8080;
    step();
    victim_hit_i  = 1'b0;
    step();
    check("stats_hits_saturated", LW'(victim_hits_o), LW'(16'hFFFF));
    check("stats_misses_unchanged", LW'(victim_misses_o), LW'(1));
`endif

    check("scoreboard_drained", LW'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
